// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter with a small byte FIFO in front
//
// Purpose:
//   Producers push reply/status bytes through a valid/ready handshake into a
//   FIFO_DEPTH-entry FIFO. A four-state framer (IDLE, START, DATA, STOP) pops
//   bytes and serializes them LSB first as 1 start bit, 8 data bits, 1 stop
//   bit, each held CLKS_PER_BIT = CLK_FREQ/BAUD_RATE cycles. Queued bytes are
//   sent back to back with no idle gap between frames.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   rst           in   1   synchronous reset, active-high
//   data_i        in   8   byte to transmit, sampled only on an accepted push
//   valid_i       in   1   data_i valid this cycle
//   ready_o       out  1   FIFO not full; push happens on valid_i && ready_o
//   uart_tx_o     out  1   serial line, idle high, registered
//   busy_o        out  1   frame on the line or bytes queued
//   fifo_level_o  out  L   queued bytes not yet started, L = $clog2(FIFO_DEPTH+1)

`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic                              uart_tx_o,
  output logic                              busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  logic            push;
  logic            pop;
  logic            baud_end;
  logic            fifo_nonempty;

  assign fifo_nonempty = (level != '0);
  assign baud_end      = (baud_cnt == BAUD_LAST);

  // Full means not ready even if the framer pops this cycle: no pass-through.
  assign ready_o = (level != LEVEL_FULL);
  assign push    = valid_i && ready_o;

  // The framer takes a byte either from idle or at the last cycle of a stop
  // bit, which is what makes consecutive frames seamless.
  assign pop = fifo_nonempty &&
               ((state == IDLE) || ((state == STOP) && baud_end));

  assign fifo_level_o = level;
  assign busy_o       = (state != IDLE) || fifo_nonempty;

  // Storage is not reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (!push && pop) begin
        level <= level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      uart_tx_o <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx_o <= 1'b1;
          baud_cnt  <= '0;
          if (pop) begin
            shift     <= mem[rd_ptr];
            uart_tx_o <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            uart_tx_o <= shift[0];
            bit_idx   <= '0;
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx_o <= 1'b1;
              state     <= STOP;
            end else begin
              // shift[1] becomes the new LSB, so drive it now.
              shift     <= {1'b0, shift[7:1]};
              uart_tx_o <= shift[1];
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift     <= mem[rd_ptr];
              uart_tx_o <= 1'b0;
              state     <= START;
            end else begin
              uart_tx_o <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: begin
          uart_tx_o <= 1'b1;
          baud_cnt  <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo

`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int DEPTH     = 4;
  localparam int CPB       = 10;
  localparam int FRAME     = 10 * CPB;
  localparam int LW        = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data_i = 8'h00;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          uart_tx_o;
  logic          busy_o;
  logic [LW-1:0] fifo_level_o;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .uart_tx_o    (uart_tx_o),
    .busy_o       (busy_o),
    .fifo_level_o (fifo_level_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Model: a queue of accepted-but-unstarted bytes plus the position inside
  // the current frame (m_t = cycles since the start bit began, -1 when idle).
  logic [7:0] m_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] m_cur = 8'h00;
  int         m_t = -1;
  bit         m_acc;
  bit         saw_rst = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      exp_bytes.delete();
      m_t = -1;
      saw_rst = 1'b1;
    end else begin
      m_acc = valid_i && (m_q.size() < DEPTH);
      if (m_t >= 0) m_t++;
      if (m_t == FRAME) m_t = -1;
      if (m_t < 0 && m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_t = 0;
      end
      if (m_acc) begin
        m_q.push_back(data_i);
        exp_bytes.push_back(data_i);
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (m_t < 0) return 1'b1;
    k = m_t / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[3'(k - 1)];
  endfunction

  // Compare process plus an independent line monitor that decodes frames.
  bit         chk_on = 1'b0;
  int         mon_c = -1;
  int         mk;
  logic [7:0] mon_sh = 8'h00;
  logic [7:0] mon_log[$];
  int         fall_times[$];

  always @(negedge clk) begin
    if (chk_on) begin
      check("tx", 32'(uart_tx_o), 32'(exp_tx()));
      check("ready", 32'(ready_o), 32'(m_q.size() < DEPTH));
      check("busy", 32'(busy_o), 32'((m_t >= 0) || (m_q.size() != 0)));
      check("level", 32'(fifo_level_o), 32'(m_q.size()));
      if (busy_o === 1'b0) check("idle_line_high", 32'(uart_tx_o), 32'd1);

      if (saw_rst) begin
        mon_c = -1;
        saw_rst = 1'b0;
      end else if (mon_c < 0) begin
        if (uart_tx_o === 1'b0) begin
          mon_c = 0;
          fall_times.push_back(cyc);
        end
      end else begin
        mon_c++;
      end
      if (mon_c >= 0 && (mon_c % CPB) == CPB / 2) begin
        mk = mon_c / CPB;
        if (mk == 0) begin
          check("mon_start_bit", 32'(uart_tx_o), 32'd0);
        end else if (mk <= 8) begin
          mon_sh[3'(mk - 1)] = uart_tx_o;
        end else begin
          check("mon_stop_bit", 32'(uart_tx_o), 32'd1);
          if (exp_bytes.size() == 0) begin
            n_checks++;
            $display("FAIL mon_byte: got 0x%0h, expected no byte (cycle %0d)", mon_sh, cyc);
          end else begin
            check("mon_byte", 32'(mon_sh), 32'(exp_bytes.pop_front()));
          end
          mon_log.push_back(mon_sh);
          mon_c = -1;
        end
      end
    end
  end

  int full_pops = 0;

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic push_byte(input logic [7:0] b, input int budget);
    int waited;
    bit pop_now;
    waited = 0;
    valid_i = 1'b1;
    data_i = b;
    while (ready_o !== 1'b1 && waited < budget) begin
      pop_now = (m_t == FRAME - 1);
      @(negedge clk);
      waited++;
      if (pop_now) begin
        check("full_pop_no_push", 32'(fifo_level_o), DEPTH - 1);
        full_pops++;
      end
    end
    if (ready_o !== 1'b1) begin
      check("push_timeout", 32'(ready_o), 32'd1);
      valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy_low", 32'(busy_o), 32'd0);
  endtask

  logic [9:0] seq_a5 = 10'b1101001010;
  logic [7:0] t2v[5] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h81};
  logic [7:0] t6v[$];
  int         base;
  int         n;
  logic [7:0] rb;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("rst_tx", 32'(uart_tx_o), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single byte 0xA5, bit-by-bit timing.
    base = mon_log.size();
    push_byte(8'hA5, 10);
    check("t1_tx_before_fall", 32'(uart_tx_o), 32'd1);
    repeat (6) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t1_bit%0d", k), 32'(uart_tx_o), 32'(seq_a5[k]));
      if (k < 9) repeat (10) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("t1_busy_at_n100", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("t1_busy_at_n101", 32'(busy_o), 32'd0);
    check("t1_tx_at_n101", 32'(uart_tx_o), 32'd1);
    check("t1_count", 32'(mon_log.size() - base), 32'd1);
    if (mon_log.size() > base) check("t1_byte", 32'(mon_log[base]), 32'hA5);
    repeat (3) @(negedge clk);

    // 2: five back-to-back bytes fill the FIFO, frames seamless.
    base = mon_log.size();
    fall_times.delete();
    for (int i = 0; i < 5; i++) push_byte(t2v[i], 10);
    check("t2_level_full", 32'(fifo_level_o), 32'd4);
    check("t2_ready_low", 32'(ready_o), 32'd0);
    wait_idle(700);
    check("t2_frames", 32'(fall_times.size()), 32'd5);
    for (int i = 1; i < 5 && i < fall_times.size(); i++)
      check($sformatf("t2_start_gap%0d", i), 32'(fall_times[i] - fall_times[i-1]), 32'd100);
    check("t2_count", 32'(mon_log.size() - base), 32'd5);
    for (int i = 0; i < 5 && base + i < mon_log.size(); i++)
      check($sformatf("t2_byte%0d", i), 32'(mon_log[base+i]), 32'(t2v[i]));
    repeat (3) @(negedge clk);

    // 3: producer holds valid while full across pop cycles.
    base = mon_log.size();
    full_pops = 0;
    for (int i = 0; i < 10; i++) push_byte(8'hC0 + 8'(i), 400);
    check("t3_full_pop_seen", 32'(full_pops > 0), 32'd1);
    wait_idle(1200);
    check("t3_count", 32'(mon_log.size() - base), 32'd10);
    for (int i = 0; i < 10 && base + i < mon_log.size(); i++)
      check($sformatf("t3_byte%0d", i), 32'(mon_log[base+i]), 32'(8'hC0 + 8'(i)));
    repeat (3) @(negedge clk);

    // 4: reset 37 clocks into frame 0x3C with two bytes queued.
    base = mon_log.size();
    push_byte(8'h3C, 10);
    push_byte(8'h11, 10);
    push_byte(8'h22, 10);
    check("t4_level_queued", 32'(fifo_level_o), 32'd2);
    repeat (35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_tx", 32'(uart_tx_o), 32'd1);
    check("t4_level", 32'(fifo_level_o), 32'd0);
    check("t4_busy", 32'(busy_o), 32'd0);
    check("t4_ready", 32'(ready_o), 32'd1);
    repeat (300) @(negedge clk);
    check("t4_tx_idle", 32'(uart_tx_o), 32'd1);
    check("t4_busy_idle", 32'(busy_o), 32'd0);
    check("t4_no_bytes", 32'(mon_log.size() - base), 32'd0);

    // 5: push and pop on the same STOP-end edge with level 2.
    base = mon_log.size();
    push_byte(8'h61, 10);
    push_byte(8'h62, 10);
    push_byte(8'h63, 10);
    n = 0;
    while (m_t != FRAME - 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_level_before", 32'(fifo_level_o), 32'd2);
    valid_i = 1'b1;
    data_i = 8'h64;
    @(negedge clk);
    valid_i = 1'b0;
    check("t5_level_after", 32'(fifo_level_o), 32'd2);
    check("t5_no_gap", 32'(uart_tx_o), 32'd0);
    wait_idle(600);
    check("t5_count", 32'(mon_log.size() - base), 32'd4);
    for (int i = 0; i < 4 && base + i < mon_log.size(); i++)
      check($sformatf("t5_byte%0d", i), 32'(mon_log[base+i]), 32'(8'h61 + 8'(i)));
    repeat (3) @(negedge clk);

    // 6: 200 random bytes with random gaps.
    base = mon_log.size();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(50, 300)) @(negedge clk);
      else repeat ($urandom_range(0, 2)) @(negedge clk);
      rb = 8'($urandom);
      t6v.push_back(rb);
      push_byte(rb, 1000);
    end
    wait_idle(1000);
    check("t6_count", 32'(mon_log.size() - base), 32'd200);
    for (int i = 0; i < 200 && base + i < mon_log.size(); i++)
      check("t6_byte", 32'(mon_log[base+i]), 32'(t6v[i]));

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
